// File: rtl/m_condcode_ser.sv
// m_condcode_ser: slice-serial compare producing RISC-V less-than, equality and branch-taken flags.
module m_condcode_ser #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             raluF,
  output logic             req,
  output logic             is_brcond
);
  localparam int NS = WIDTH / SLICE;
  localparam int CW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic carry, eqacc, valid;
  logic [2:0] f3;
  logic [WIDTH-1:0] a_r, b_r;
  logic [SLICE-1:0] a_s, b_s;
  logic accept, step, last, carry_n, eq_n, ult, slt, lt_n;
  assign accept = start && state != RUN;
  assign step = state == RUN && !hold;
  assign last = cnt == CW'(NS - 1);
  assign a_s = a_r[int'(cnt) * SLICE +: SLICE];
  assign b_s = b_r[int'(cnt) * SLICE +: SLICE];
  // carry out of a + ~b + carry: set when a > b, or a == b and carry-in set
  assign carry_n = (a_s > b_s) | ((a_s == b_s) & carry);
  assign eq_n = eqacc & (a_s == b_s);
  assign ult = ~carry_n;
  assign slt = (a_r[WIDTH-1] & ~b_r[WIDTH-1]) | (~(a_r[WIDTH-1] ^ b_r[WIDTH-1]) & ~carry_n);
  assign lt_n = (f3[2] | f3[1]) & ((f3[2] ? f3[1] : f3[0]) ? ult : slt);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign is_brcond = valid & (f3[2] ? raluF ^ f3[0] : ~f3[1] & (req ^ f3[0]));
  always_comb begin
    state_n = accept ? RUN : state == DONE ? IDLE : (step && last) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      carry <= 1'b1;
      eqacc <= 1'b1;
      valid <= 1'b0;
      raluF <= 1'b0;
      req <= 1'b0;
      f3 <= 3'b000;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      f3 <= func3;
      cnt <= '0;
      carry <= 1'b1;
      eqacc <= 1'b1;
      valid <= 1'b0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      carry <= carry_n;
      eqacc <= eq_n;
      if (last) begin
        raluF <= lt_n;
        req <= eq_n;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_m_condcode_ser.sv
// tb_m_condcode_ser: directed and random compares against an arithmetic reference model.
module tb_m_condcode_ser;
  logic clk = 0, rst, start, hold;
  logic [2:0] func3;
  logic [31:0] a, b;
  logic busy, done, raluF, req, is_brcond;
  logic busy2, done2, raluF2, req2, is_brcond2;
  int checks = 0, errors = 0;

  m_condcode_ser #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .a(a), .b(b), .hold(hold),
    .busy(busy), .done(done), .raluF(raluF), .req(req), .is_brcond(is_brcond));
  m_condcode_ser #(.WIDTH(32), .SLICE(32)) dut2 (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .a(a), .b(b), .hold(hold),
    .busy(busy2), .done(done2), .raluF(raluF2), .req(req2), .is_brcond(is_brcond2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_lt(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    case (f)
      3'b010, 3'b100, 3'b101: return $signed(x) < $signed(y);
      3'b011, 3'b110, 3'b111: return x < y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    case (f)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return !($signed(x) < $signed(y));
      3'b110: return x < y;
      3'b111: return !(x < y);
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; hold is raised for h_len edges starting after edge h_at.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf,
                        input int h_at, input int h_len, input string tag);
    int c;
    logic e_lt, e_br;
    e_lt = ref_lt(ta, tb, tf);
    e_br = ref_br(ta, tb, tf);
    a = ta; b = tb; func3 = tf; start = 1;
    @(negedge clk);
    start = 0;
    c = 0;
    while (!done && c < 40) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " br_run"}, is_brcond, 0);
      hold = (h_len > 0) && c >= h_at && c < h_at + h_len;
      @(negedge clk);
      c++;
    end
    hold = 0;
    check({tag, " latency"}, c, 4 + h_len);
    check({tag, " lt"}, raluF, e_lt);
    check({tag, " eq"}, req, ta == tb);
    check({tag, " br"}, is_brcond, e_br);
    check({tag, " busy_done"}, busy, 0);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " lt_hold"}, raluF, e_lt);
    check({tag, " br_hold"}, is_brcond, e_br);
  endtask

  logic [31:0] oa [8], ob [8];
  logic [2:0] of [8];
  int ndone, prev, seen;
  logic just;
  logic [31:0] ra, rb;
  logic [2:0] rf;

  initial begin
    rst = 1; start = 0; hold = 0; a = 0; b = 0; func3 = 0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst lt", raluF, 0);
    check("rst eq", req, 0);
    check("rst br", is_brcond, 0);
    check("rst br2", is_brcond2, 0);
    rst = 0;
    @(negedge clk);

    run_op(32'd5, 32'd5, 3'b000, 0, 0, "eq5");
    run_op(32'hFFFF_FFFF, 32'd1, 3'b100, 0, 0, "blt");
    run_op(32'hFFFF_FFFF, 32'd1, 3'b110, 0, 0, "bltu");
    run_op(32'h0000_0100, 32'h0000_0200, 3'b011, 2, 3, "sltu_hold");

    // reset in the middle of a run abandons it
    a = 32'h1234; b = 32'h1234; func3 = 3'b000; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst lt", raluF, 0);
    check("midrst eq", req, 0);
    check("midrst br", is_brcond, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("midrst no_done", seen, 0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 0, 0, "after_rst");

    // start held high: accepts only at DONE, operands switch while RUN
    for (int i = 0; i < 8; i++) begin
      oa[i] = (i % 2) ? 32'h0000_0010 : 32'hFFFF_FFF0;
      ob[i] = (i % 2) ? 32'hFFFF_FFF0 : 32'h0000_0010;
      of[i] = (i % 2) ? 3'b110 : 3'b100;
    end
    a = oa[0]; b = ob[0]; func3 = of[0]; start = 1;
    @(negedge clk);
    a = oa[1]; b = ob[1]; func3 = of[1];
    ndone = 0; prev = 0; just = 0;
    for (int c = 0; c <= 24; c++) begin
      if (done) begin
        check("b2b lt", raluF, ref_lt(oa[ndone], ob[ndone], of[ndone]));
        check("b2b br", is_brcond, ref_br(oa[ndone], ob[ndone], of[ndone]));
        check("b2b gap", ndone > 0 ? c - prev : c, ndone > 0 ? 5 : 4);
        prev = c;
        ndone++;
        just = 1;
      end else begin
        check("b2b busy", busy, 1);
        if (just) begin
          a = oa[ndone + 1]; b = ob[ndone + 1]; func3 = of[ndone + 1];
          just = 0;
        end
      end
      @(negedge clk);
    end
    start = 0;
    check("b2b count", ndone, 5);
    repeat (6) @(negedge clk);

    // single-slice instance finishes one edge after accept
    a = 32'h8000_0000; b = 32'h0; func3 = 3'b101; start = 1;
    @(negedge clk);
    start = 0;
    check("s32 busy", busy2, 1);
    check("s32 done_early", done2, 0);
    @(negedge clk);
    check("s32 done", done2, 1);
    check("s32 lt", raluF2, 1);
    check("s32 br", is_brcond2, 0);
    check("s32 eq", req2, 0);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 32'h8000_0000;
        2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      rf = 3'($urandom_range(0, 7));
      run_op(ra, rb, rf, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
